// File: rtl/rf_timing_pkg.sv
// Shared types and defaults for the RF TX timing generator.
// Channel FSM encoding and default widths/depths.
package rf_timing_pkg;

  localparam int CH_NUM_DEF      = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 3;
  localparam int CPI_CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_DELAY,
    CH_PULSE,
    CH_DONE
  } ch_state_e;

endpackage

// File: rtl/rf_tx_timing_gen_if.sv
// Host/front-end signal bundle of the RF TX timing generator.
// master = host side, slave = timing generator.
interface rf_tx_timing_gen_if
  import rf_timing_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int CPI_CNT_W = CPI_CNT_W_DEF
) ();

  logic [CH_NUM-1:0]       i_tx_ctrl;
  logic                    i_init;
  logic                    i_stop;
  logic                    i_pre_cpi;
  logic                    i_cpi;
  logic [CH_NUM-1:0]       i_ch_en;
  logic [CH_NUM*CNT_W-1:0] i_dly;
  logic [CH_NUM*CNT_W-1:0] i_width;
  logic [CH_NUM-1:0]       o_tx_ctrl;
  logic                    o_ctrl_over_flag;
  logic                    o_busy;
  logic                    o_retrig_err;
  logic [CPI_CNT_W-1:0]    o_cpi_cnt;

  modport master (
    output i_tx_ctrl, i_init, i_stop,
    output i_pre_cpi, i_cpi,
    output i_ch_en, i_dly, i_width,
    input  o_tx_ctrl, o_ctrl_over_flag,
    input  o_busy, o_retrig_err, o_cpi_cnt
  );

  modport slave (
    input  i_tx_ctrl, i_init, i_stop,
    input  i_pre_cpi, i_cpi,
    input  i_ch_en, i_dly, i_width,
    output o_tx_ctrl, o_ctrl_over_flag,
    output o_busy, o_retrig_err, o_cpi_cnt
  );

endinterface

// File: rtl/rf_tx_ch_seq.sv
// One TX channel: delay then pulse, parked in DONE until the
// burst is released. Width is held locally for the delay phase.
module rf_tx_ch_seq
  import rf_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic             fin,
  input  logic             en,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] width,
  output logic             pulse,
  output logic             done
);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] w_q, w_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CH_IDLE;
      cnt   <= '0;
      w_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      w_q   <= w_nxt;
    end
  end

  // cnt holds remaining cycles minus one in DELAY and PULSE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    w_nxt     = w_q;
    if (clr) begin
      state_nxt = CH_IDLE;
    end else begin
      case (state)
        CH_IDLE: begin
          if (start) begin
            w_nxt = width;
            if (!en || width == '0) begin
              state_nxt = CH_DONE;
            end else if (dly == '0) begin
              state_nxt = CH_PULSE;
              cnt_nxt   = width - 1'b1;
            end else begin
              state_nxt = CH_DELAY;
              cnt_nxt   = dly - 1'b1;
            end
          end
        end
        CH_DELAY: begin
          if (cnt == '0) begin
            state_nxt = CH_PULSE;
            cnt_nxt   = w_q - 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        CH_PULSE: begin
          if (cnt == '0) state_nxt = CH_DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        CH_DONE: begin
          if (fin) state_nxt = CH_IDLE;
        end
        default: state_nxt = CH_IDLE;
      endcase
    end
  end

  assign pulse = (state == CH_PULSE);
  assign done  = (state == CH_DONE);

endmodule

// File: rtl/rf_tx_timing_gen.sv
// Multi-channel RF TX timing generator: per-channel delayed pulses
// on each pre-CPI edge in auto mode, passthrough in manual mode.
module rf_tx_timing_gen
  import rf_timing_pkg::*;
#(
  parameter int CH_NUM      = CH_NUM_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CPI_CNT_W   = CPI_CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  rf_tx_timing_gen_if.slave bus
);

  logic [SYNC_STAGES-1:0] pre_sync, cpi_sync;
  logic                   pre_last, cpi_last;
  logic                   pre_pedge, cpi_pedge;

  logic                   mode, mode_nxt;
  logic                   busy, over, retrig;
  logic [CH_NUM-1:0]      tx_q;
  logic [CPI_CNT_W-1:0]   cpi_cnt;

  logic                   accept, retrig_nxt;
  logic                   burst_end, ch_clr;
  logic [CH_NUM-1:0]      ch_pulse, ch_done;

  // edge flags are registered so they line up one edge after the sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_sync  <= '0;
      cpi_sync  <= '0;
      pre_last  <= 1'b0;
      cpi_last  <= 1'b0;
      pre_pedge <= 1'b0;
      cpi_pedge <= 1'b0;
    end else begin
      pre_sync  <= {pre_sync[SYNC_STAGES-2:0], bus.i_pre_cpi};
      cpi_sync  <= {cpi_sync[SYNC_STAGES-2:0], bus.i_cpi};
      pre_last  <= pre_sync[SYNC_STAGES-1];
      cpi_last  <= cpi_sync[SYNC_STAGES-1];
      pre_pedge <= pre_sync[SYNC_STAGES-1] & ~pre_last;
      cpi_pedge <= cpi_sync[SYNC_STAGES-1] & ~cpi_last;
    end
  end

  always_comb begin
    mode_nxt = mode;
    if (bus.i_stop)      mode_nxt = 1'b0;
    else if (bus.i_init) mode_nxt = 1'b1;
  end

  assign accept     = mode & mode_nxt & pre_pedge & ~busy;
  assign retrig_nxt = mode & mode_nxt & pre_pedge & busy;
  assign burst_end  = busy & mode_nxt & (&ch_done);
  assign ch_clr     = ~mode_nxt;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    rf_tx_ch_seq #(
      .CNT_W (CNT_W)
    ) u_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ch_clr),
      .start (accept),
      .fin   (burst_end),
      .en    (bus.i_ch_en[k]),
      .dly   (bus.i_dly[k*CNT_W +: CNT_W]),
      .width (bus.i_width[k*CNT_W +: CNT_W]),
      .pulse (ch_pulse[k]),
      .done  (ch_done[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode    <= 1'b0;
      busy    <= 1'b0;
      over    <= 1'b0;
      retrig  <= 1'b0;
      tx_q    <= '0;
      cpi_cnt <= '0;
    end else begin
      mode   <= mode_nxt;
      busy   <= mode_nxt & (accept | (busy & ~burst_end));
      over   <= burst_end;
      retrig <= retrig_nxt;
      tx_q   <= mode_nxt ? ch_pulse : bus.i_tx_ctrl;
      if (bus.i_init)     cpi_cnt <= '0;
      else if (cpi_pedge) cpi_cnt <= cpi_cnt + 1'b1;
    end
  end

  assign bus.o_tx_ctrl        = tx_q;
  assign bus.o_ctrl_over_flag = over;
  assign bus.o_busy           = busy;
  assign bus.o_retrig_err     = retrig;
  assign bus.o_cpi_cnt        = cpi_cnt;

endmodule

// File: tb/tb_rf_tx_timing_gen.sv
// Scoreboard bench for rf_tx_timing_gen: expected output events
// are queued by the stimulus and popped by a negedge monitor.
module tb_rf_tx_timing_gen;
  import rf_timing_pkg::*;

  localparam int CH   = 4;
  localparam int CW   = 16;
  localparam int CPW  = 16;
  localparam int CPW2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_tx_timing_gen_if #(.CH_NUM(CH), .CNT_W(CW), .CPI_CNT_W(CPW))  bus ();
  rf_tx_timing_gen_if #(.CH_NUM(CH), .CNT_W(CW), .CPI_CNT_W(CPW2)) bus2 ();

  rf_tx_timing_gen #(
    .CH_NUM(CH), .CNT_W(CW), .SYNC_STAGES(3), .CPI_CNT_W(CPW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // narrow CPI counter instance for the wrap check
  rf_tx_timing_gen #(
    .CH_NUM(CH), .CNT_W(CW), .SYNC_STAGES(3), .CPI_CNT_W(CPW2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  assign bus2.i_tx_ctrl = '0;
  assign bus2.i_init    = 1'b0;
  assign bus2.i_stop    = 1'b0;
  assign bus2.i_pre_cpi = 1'b0;
  assign bus2.i_cpi     = bus.i_cpi;
  assign bus2.i_ch_en   = '0;
  assign bus2.i_dly     = '0;
  assign bus2.i_width   = '0;

  typedef struct packed {
    int         cyc;
    logic [3:0] tx;
    logic       over;
    logic       err;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs, want;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev_tx = 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_tx_ctrl !== prev_tx || bus.o_ctrl_over_flag !== 1'b0 ||
          bus.o_retrig_err !== 1'b0) begin
        obs = '{cyc, bus.o_tx_ctrl, bus.o_ctrl_over_flag, bus.o_retrig_err};
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got cyc=%0d tx=%b over=%b err=%b, required no event",
                   obs.cyc, obs.tx, obs.over, obs.err);
        end else begin
          want = exp_q.pop_front();
          if (obs === want) n_pass++;
          else $display("FAIL sb_event: got cyc=%0d tx=%b over=%b err=%b, required cyc=%0d tx=%b over=%b err=%b",
                        obs.cyc, obs.tx, obs.over, obs.err,
                        want.cyc, want.tx, want.over, want.err);
        end
      end
      prev_tx = bus.o_tx_ctrl;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic expect_ev(input int c, input logic [3:0] t,
                           input logic o, input logic e);
    exp_q.push_back('{c, t, o, e});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // position so that the next rising edge is edge number x
  task automatic to_edge(input int x);
    while (cyc < x - 1) tick(1);
  endtask

  task automatic cpi_pulses(input int n);
    repeat (n) begin
      bus.i_cpi = 1'b1;
      tick(2);
      bus.i_cpi = 1'b0;
      tick(2);
    end
    tick(6);
  endtask

  task automatic pulse_init();
    bus.i_init = 1'b1;
    tick(1);
    bus.i_init = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  int e0, e1, e2, e3;

  initial begin
    bus.i_tx_ctrl = '0;
    bus.i_init    = 1'b0;
    bus.i_stop    = 1'b0;
    bus.i_pre_cpi = 1'b0;
    bus.i_cpi     = 1'b0;
    bus.i_ch_en   = '0;
    bus.i_dly     = '0;
    bus.i_width   = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    chk("rst_tx", int'(bus.o_tx_ctrl), 0);
    chk("rst_over", int'(bus.o_ctrl_over_flag), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_err", int'(bus.o_retrig_err), 0);
    chk("rst_cpi", int'(bus.o_cpi_cnt), 0);

    // manual passthrough, triggers ignored
    bus.i_tx_ctrl = 4'b1010;
    expect_ev(cyc + 1, 4'b1010, 1'b0, 1'b0);
    tick(2);
    bus.i_pre_cpi = 1'b1;
    tick(5);
    chk("man_busy", int'(bus.o_busy), 0);
    bus.i_pre_cpi = 1'b0;
    tick(4);
    bus.i_tx_ctrl = 4'b0000;
    expect_ev(cyc + 1, 4'b0000, 1'b0, 1'b0);
    tick(3);

    // main burst with mid-burst retrigger
    pulse_init();
    bus.i_ch_en = 4'hF;
    bus.i_dly   = {16'd0, 16'd10, 16'd5, 16'd0};
    bus.i_width = {16'd0, 16'd1, 16'd3, 16'd200};
    tick(2);
    e0 = cyc + 1;
    bus.i_pre_cpi = 1'b1;
    expect_ev(e0 + 5,   4'b0001, 1'b0, 1'b0);
    expect_ev(e0 + 10,  4'b0011, 1'b0, 1'b0);
    expect_ev(e0 + 13,  4'b0001, 1'b0, 1'b0);
    expect_ev(e0 + 15,  4'b0101, 1'b0, 1'b0);
    expect_ev(e0 + 16,  4'b0001, 1'b0, 1'b0);
    expect_ev(e0 + 54,  4'b0001, 1'b0, 1'b1);
    expect_ev(e0 + 205, 4'b0000, 1'b1, 1'b0);
    to_edge(e0 + 20);
    bus.i_pre_cpi = 1'b0;
    bus.i_dly   = {16'd0, 16'd0, 16'd0, 16'd2};
    bus.i_width = {16'd0, 16'd0, 16'd0, 16'd4};
    to_edge(e0 + 31);
    chk("burst_busy", int'(bus.o_busy), 1);
    to_edge(e0 + 50);
    bus.i_pre_cpi = 1'b1;
    to_edge(e0 + 60);
    bus.i_pre_cpi = 1'b0;

    // new burst 10 cycles after over_flag, using the config set mid-burst
    to_edge(e0 + 215);
    e1 = e0 + 215;
    bus.i_pre_cpi = 1'b1;
    expect_ev(e1 + 7,  4'b0001, 1'b0, 1'b0);
    expect_ev(e1 + 11, 4'b0000, 1'b1, 1'b0);
    to_edge(e1 + 20);
    bus.i_pre_cpi = 1'b0;
    to_edge(e1 + 30);
    chk("burst2_idle", int'(bus.o_busy), 0);

    // stop during ch0 pulse
    bus.i_ch_en   = 4'b0001;
    bus.i_dly     = '0;
    bus.i_width   = {16'd0, 16'd0, 16'd0, 16'd100};
    bus.i_tx_ctrl = 4'b0110;
    to_edge(e1 + 40);
    e2 = e1 + 40;
    bus.i_pre_cpi = 1'b1;
    expect_ev(e2 + 5,  4'b0001, 1'b0, 1'b0);
    expect_ev(e2 + 20, 4'b0110, 1'b0, 1'b0);
    to_edge(e2 + 10);
    bus.i_pre_cpi = 1'b0;
    to_edge(e2 + 20);
    bus.i_stop = 1'b1;
    tick(1);
    bus.i_stop = 1'b0;
    chk("stop_busy", int'(bus.o_busy), 0);
    to_edge(e2 + 150);
    bus.i_tx_ctrl = 4'b0000;
    expect_ev(cyc + 1, 4'b0000, 1'b0, 1'b0);
    tick(2);

    // init and stop together stay in manual
    bus.i_init = 1'b1;
    bus.i_stop = 1'b1;
    tick(1);
    bus.i_init = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_tx_ctrl = 4'b1001;
    expect_ev(cyc + 1, 4'b1001, 1'b0, 1'b0);
    tick(2);
    bus.i_pre_cpi = 1'b1;
    tick(5);
    chk("initstop_busy", int'(bus.o_busy), 0);
    bus.i_pre_cpi = 1'b0;
    tick(3);
    bus.i_tx_ctrl = 4'b0000;
    expect_ev(cyc + 1, 4'b0000, 1'b0, 1'b0);
    tick(2);

    // all channels disabled: one busy cycle then over_flag
    pulse_init();
    bus.i_ch_en = 4'b0000;
    bus.i_width = {16'd0, 16'd0, 16'd0, 16'd50};
    tick(2);
    e3 = cyc + 1;
    bus.i_pre_cpi = 1'b1;
    expect_ev(e3 + 5, 4'b0000, 1'b1, 1'b0);
    tick(5);
    chk("noen_busy_on", int'(bus.o_busy), 1);
    tick(1);
    chk("noen_busy_off", int'(bus.o_busy), 0);
    bus.i_pre_cpi = 1'b0;
    tick(5);

    // CPI counting, clear and wrap
    cpi_pulses(8);
    chk("cpi_8", int'(bus.o_cpi_cnt), 8);
    chk("cpi2_8", int'(bus2.o_cpi_cnt), 8);
    pulse_init();
    chk("cpi_clr", int'(bus.o_cpi_cnt), 0);
    cpi_pulses(3);
    chk("cpi_3", int'(bus.o_cpi_cnt), 3);
    chk("cpi2_11", int'(bus2.o_cpi_cnt), 11);
    cpi_pulses(4);
    chk("cpi2_15", int'(bus2.o_cpi_cnt), 15);
    cpi_pulses(1);
    chk("cpi2_wrap", int'(bus2.o_cpi_cnt), 0);
    chk("cpi_8b", int'(bus.o_cpi_cnt), 8);

    tick(20);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
